missile_pool: RTL and testbench
===============================

// Module: missile_pool
// PURPOSE
//  Multi-missile launcher/tracker for the player ship; the parametrised successor of the single-missile block.
//  Manages NUM_MISSILES independent slots, launches on a fire-key press edge with a cooldown,
//  and advances every active missile upward once per frame.
//  Retires a missile on the top edge or on its own collision bit.
//  Sits between the keycode/ship-position logic and the colour mapper / collision detector.
// PARAMETERS
//  NUM_MISSILES  4      number of missile slots (1..8)
//  STEP_Y        4      upward pixels moved per frame by an active missile
//  COOLDOWN      8      frames after a launch during which no new launch is accepted
//  SIZE_X        4      missile width in pixels (driven on MissileSX)
//  SIZE_Y        6      missile height in pixels (driven on MissileSY)
//  Y_MIN         0      topmost legal Y; a missile that would pass it is retired
//  FIRE_KEY      8'h1A  keycode that fires (W)
// PORTS
//  frame_clk      in   1        frame clock; all state updates on its rising edge
//  Reset          in   1        synchronous, active-high reset
//  keycode        in   8        current key from the keyboard interface
//  ShipX          in   10       ship top-left X
//  ShipY          in   10       ship top-left Y
//  Ship_sizeX     in   10       ship width
//  Collision      in   N        per-slot hit flag; bit i retires slot i
//  MissileX       out  10*N     slot i X at bits [10i+9:10i]
//  MissileY       out  10*N     slot i Y at bits [10i+9:10i]
//  MissileActive  out  N        slot i in flight; draw only when set
//  MissileSX      out  10       constant SIZE_X
//  MissileSY      out  10       constant SIZE_Y
//  FireAck        out  1        one-frame pulse in the frame a launch occurs
// BEHAVIOUR
//  Reset values:
//   - MissileActive=0, MissileX/Y=0 for every slot, FireAck=0, cooldown=0.
//   - Key-held register=1, so a key held through reset does not fire.
//  Slot states: IDLE, FLYING (one bit per slot = MissileActive[i]).
//  Fire request (evaluated every frame_clk edge):
//   - Request when keycode==FIRE_KEY and key-held register==0 (press edge).
//   - key_held <= (keycode==FIRE_KEY) every cycle.
//  Launch:
//   - Occurs when a fire request is present, cooldown==0, and at least one slot is IDLE at the start of the cycle.
//   - The lowest-index IDLE slot goes FLYING with X = ShipX + Ship_sizeX/2 and Y = ShipY.
//   - FireAck=1 that cycle only; cooldown <= COOLDOWN.
//   - Outputs show the new missile one cycle after the sampling edge.
//  Rejected fire (cooldown>0 or all slots FLYING): the request is dropped, not queued; FireAck=0.
//  Cooldown: decrements by 1 per frame while >0; saturates at 0.
//  FLYING slot i, per frame, in priority order:
//   1. Collision[i]==1 -> IDLE, X/Y <= 0.
//   2. Y < Y_MIN + STEP_Y -> IDLE, X/Y <= 0 (no unsigned wrap ever observed).
//   3. Otherwise Y <= Y - STEP_Y; X unchanged.
//  Collision[i] on an IDLE slot is ignored.
//  A slot freed this cycle is not launchable until the next cycle.
//  Arithmetic: 10-bit unsigned; Ship_sizeX/2 is a right shift; sums truncate to 10 bits.
//  Reset asserted mid-flight: all slots return to IDLE at that edge; cooldown cleared.
// TESTING
//  1. Reset, hold keycode=00, then 1A for 1 frame with ShipX=300, ShipY=400, Ship_sizeX=32
//     -> slot0 active, X=316, Y=400, FireAck pulse; next frame Y=396.
//  2. Hold 1A for 20 frames -> exactly one launch (edge-triggered).
//  3. Press 1A twice, 3 frames apart -> second press ignored (cooldown 8);
//     a press after 9 frames launches into slot1.
//  4. Four launches spaced 10 frames -> slots 0..3 active; fifth press -> no launch, FireAck=0;
//     Collision[2]=1 -> slot2 idle next cycle; next press fills slot2.
//  5. Slot at Y=5, STEP_Y=4 -> Y=1, then retires to idle (X=Y=0), never wraps to 1021.
//  6. Reset asserted with 3 slots flying and 1A held -> all idle, no launch until 1A is released and re-pressed.

Source files
------------

// File: rtl/missile_pool.sv
// missile_pool: multi-slot missile launcher and tracker for the player ship.
// Launches on a fire-key press edge into the lowest free slot, enforces a
// post-launch cooldown, moves every flying missile upward once per frame and
// retires a missile at the top edge or when its own collision bit is set.
//
// Fire request / acknowledge semantics: a request exists only on the frame
// edge where keycode first equals FIRE_KEY (press edge). It is accepted when
// the cooldown is zero and a slot is idle at the start of that frame;
// otherwise it is dropped, never queued. FireAck is high for exactly the one
// frame following an accepted request, the same frame the new missile first
// appears on the outputs.
module missile_pool #(
    parameter int          NUM_MISSILES = 4,
    parameter int          STEP_Y       = 4,
    parameter int          COOLDOWN     = 8,
    parameter int          SIZE_X       = 4,
    parameter int          SIZE_Y       = 6,
    parameter int          Y_MIN        = 0,
    parameter logic [7:0]  FIRE_KEY     = 8'h1A
) (
    input  logic                       frame_clk,
    input  logic                       Reset,
    input  logic [7:0]                 keycode,
    input  logic [9:0]                 ShipX,
    input  logic [9:0]                 ShipY,
    input  logic [9:0]                 Ship_sizeX,
    input  logic [NUM_MISSILES-1:0]    Collision,
    output logic [10*NUM_MISSILES-1:0] MissileX,
    output logic [10*NUM_MISSILES-1:0] MissileY,
    output logic [NUM_MISSILES-1:0]    MissileActive,
    output logic [9:0]                 MissileSX,
    output logic [9:0]                 MissileSY,
    output logic                       FireAck
);

    // Cooldown counter must hold COOLDOWN; keep at least one bit.
    localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

    // 11-bit compare limit so Y_MIN + STEP_Y never overflows the 10-bit range.
    localparam logic [10:0] RETIRE_LIMIT = 11'(Y_MIN + STEP_Y);
    localparam logic [9:0]  STEP_10      = 10'(STEP_Y);
    localparam logic [CD_W-1:0] CD_LOAD  = CD_W'(COOLDOWN);

    // Per-slot state; MissileActive is the direct view of this state.
    typedef enum logic {
        SLOT_IDLE   = 1'b0,
        SLOT_FLYING = 1'b1
    } slot_state_e;

    slot_state_e state_q [NUM_MISSILES];
    slot_state_e state_d [NUM_MISSILES];
    logic [9:0]  x_q     [NUM_MISSILES];
    logic [9:0]  x_d     [NUM_MISSILES];
    logic [9:0]  y_q     [NUM_MISSILES];
    logic [9:0]  y_d     [NUM_MISSILES];

    logic              key_held_q;
    logic [CD_W-1:0]   cooldown_q;
    logic [CD_W-1:0]   cooldown_d;
    logic              fire_ack_q;

    logic                    fire_req;
    logic                    free_found;
    logic [NUM_MISSILES-1:0] free_pick;
    logic                    launch;
    logic [9:0]              launch_x;

    // Press edge of the fire key; the held flag suppresses auto-repeat.
    assign fire_req = (keycode == FIRE_KEY) && !key_held_q;

    // Launch X is the ship's horizontal centre, truncated to 10 bits.
    assign launch_x = ShipX + {1'b0, Ship_sizeX[9:1]};

    // Select the lowest-index slot that is idle at the start of this frame.
    always_comb begin
        free_pick  = '0;
        free_found = 1'b0;
        for (int i = 0; i < NUM_MISSILES; i++) begin
            if (state_q[i] == SLOT_IDLE && !free_found) begin
                free_pick[i] = 1'b1;
                free_found   = 1'b1;
            end
        end
    end

    assign launch = fire_req && (cooldown_q == '0) && free_found;

    // Cooldown reloads on a launch, otherwise counts down to zero and holds.
    always_comb begin
        cooldown_d = cooldown_q;
        if (launch) begin
            cooldown_d = CD_LOAD;
        end else if (cooldown_q != '0) begin
            cooldown_d = cooldown_q - 1'b1;
        end
    end

    // Slot next-state: launch into the picked idle slot; flying slots retire
    // on collision, retire at the top edge, or step upward.
    always_comb begin
        for (int i = 0; i < NUM_MISSILES; i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            case (state_q[i])
                SLOT_IDLE: begin
                    if (launch && free_pick[i]) begin
                        state_d[i] = SLOT_FLYING;
                        x_d[i]     = launch_x;
                        y_d[i]     = ShipY;
                    end
                end
                SLOT_FLYING: begin
                    if (Collision[i]) begin
                        state_d[i] = SLOT_IDLE;
                        x_d[i]     = '0;
                        y_d[i]     = '0;
                    end else if ({1'b0, y_q[i]} < RETIRE_LIMIT) begin
                        // Another step would pass the top edge: retire
                        // instead of letting the unsigned Y wrap.
                        state_d[i] = SLOT_IDLE;
                        x_d[i]     = '0;
                        y_d[i]     = '0;
                    end else begin
                        y_d[i]     = y_q[i] - STEP_10;
                    end
                end
                default: begin
                    state_d[i] = SLOT_IDLE;
                    x_d[i]     = '0;
                    y_d[i]     = '0;
                end
            endcase
        end
    end

    // State register: slots, cooldown, key-held flag and the ack pulse.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_MISSILES; i++) begin
                state_q[i] <= SLOT_IDLE;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
            end
            // Held=1 so a fire key held through reset does not launch.
            key_held_q <= 1'b1;
            cooldown_q <= '0;
            fire_ack_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_MISSILES; i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
            end
            key_held_q <= (keycode == FIRE_KEY);
            cooldown_q <= cooldown_d;
            fire_ack_q <= launch;
        end
    end

    // Flatten per-slot registers onto the packed output buses.
    for (genvar g = 0; g < NUM_MISSILES; g++) begin : g_out
        assign MissileX[10*g +: 10] = x_q[g];
        assign MissileY[10*g +: 10] = y_q[g];
        assign MissileActive[g]     = (state_q[g] == SLOT_FLYING);
    end

    assign MissileSX = 10'(SIZE_X);
    assign MissileSY = 10'(SIZE_Y);
    assign FireAck   = fire_ack_q;

endmodule

// File: tb/tb_missile_pool.sv
// tb_missile_pool: directed stimulus for missile_pool with a frame-level
// behavioural model compared every cycle, plus literal spot checks.
module tb_missile_pool;

  localparam int N        = 4;
  localparam int STEP_Y   = 4;
  localparam int COOLDOWN = 8;
  localparam int SIZE_X   = 4;
  localparam int SIZE_Y   = 6;
  localparam int Y_MIN    = 0;
  localparam logic [7:0] FIRE = 8'h1A;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]      keycode = 8'h00;
  logic [9:0]      ship_x = 10'd300;
  logic [9:0]      ship_y = 10'd400;
  logic [9:0]      ship_sx = 10'd32;
  logic [N-1:0]    collision = '0;
  logic [10*N-1:0] missile_x;
  logic [10*N-1:0] missile_y;
  logic [N-1:0]    missile_active;
  logic [9:0]      missile_sx;
  logic [9:0]      missile_sy;
  logic            fire_ack;

  missile_pool #(
    .NUM_MISSILES(N), .STEP_Y(STEP_Y), .COOLDOWN(COOLDOWN),
    .SIZE_X(SIZE_X), .SIZE_Y(SIZE_Y), .Y_MIN(Y_MIN), .FIRE_KEY(FIRE)
  ) dut (
    .frame_clk(clk),
    .Reset(rst),
    .keycode(keycode),
    .ShipX(ship_x),
    .ShipY(ship_y),
    .Ship_sizeX(ship_sx),
    .Collision(collision),
    .MissileX(missile_x),
    .MissileY(missile_y),
    .MissileActive(missile_active),
    .MissileSX(missile_sx),
    .MissileSY(missile_sy),
    .FireAck(fire_ack)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] slot_x(input int i);
    return missile_x[10*i +: 10];
  endfunction

  function automatic logic [9:0] slot_y(input int i);
    return missile_y[10*i +: 10];
  endfunction

  // ---------------- behavioural model ----------------
  // Game-level view: a list of missiles with integer coordinates, a
  // cooldown count and the previous-frame key, updated once per frame.
  int m_active[N];
  int m_x[N];
  int m_y[N];
  int m_cd;
  int m_prev_key_fire;
  int m_ack;

  always @(posedge clk) begin
    int free_slot;
    int want;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_active[i] = 0; m_x[i] = 0; m_y[i] = 0;
      end
      m_cd = 0;
      m_prev_key_fire = 1;
      m_ack = 0;
    end else begin
      want = (keycode == FIRE) && (m_prev_key_fire == 0);
      m_prev_key_fire = (keycode == FIRE) ? 1 : 0;
      free_slot = -1;
      for (int i = N - 1; i >= 0; i--)
        if (m_active[i] == 0) free_slot = i;
      // Move the missiles that were already in the air.
      for (int i = 0; i < N; i++) begin
        if (m_active[i] != 0) begin
          if (collision[i] || (m_y[i] - STEP_Y < Y_MIN)) begin
            m_active[i] = 0; m_x[i] = 0; m_y[i] = 0;
          end else begin
            m_y[i] = m_y[i] - STEP_Y;
          end
        end
      end
      if (want && m_cd == 0 && free_slot >= 0) begin
        m_active[free_slot] = 1;
        m_x[free_slot] = (int'(ship_x) + int'(ship_sx) / 2) % 1024;
        m_y[free_slot] = int'(ship_y);
        m_cd = COOLDOWN;
        m_ack = 1;
      end else begin
        if (m_cd > 0) m_cd = m_cd - 1;
        m_ack = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [N-1:0] exp_act;
    for (int i = 0; i < N; i++) exp_act[i] = (m_active[i] != 0);
    check("model_active", 32'(missile_active), 32'(exp_act));
    for (int i = 0; i < N; i++) begin
      check($sformatf("model_x%0d", i), 32'(slot_x(i)), 32'(m_x[i]));
      check($sformatf("model_y%0d", i), 32'(slot_y(i)), 32'(m_y[i]));
    end
    check("model_ack", 32'(fire_ack), 32'(m_ack));
    check("size_x", 32'(missile_sx), 32'(SIZE_X));
    check("size_y", 32'(missile_sy), 32'(SIZE_Y));
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    keycode = 8'h00;
    collision = '0;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  // One-frame press then release; launches happen ten frames apart.
  task automatic press_and_wait();
    keycode = FIRE;
    tick(1);
    keycode = 8'h00;
    tick(9);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int acks;

    // Test 1: reset values, single launch and first step.
    tick(2);
    check("rst_active", 32'(missile_active), 32'd0);
    check("rst_ack", 32'(fire_ack), 32'd0);
    check("rst_y0", 32'(slot_y(0)), 32'd0);
    rst = 1'b0;
    tick(2);
    keycode = FIRE;
    tick(1);
    check("t1_active", 32'(missile_active), 32'd1);
    check("t1_x0", 32'(slot_x(0)), 32'd316);
    check("t1_y0", 32'(slot_y(0)), 32'd400);
    check("t1_ack", 32'(fire_ack), 32'd1);
    keycode = 8'h00;
    tick(1);
    check("t1_y0_step", 32'(slot_y(0)), 32'd396);
    check("t1_ack_pulse", 32'(fire_ack), 32'd0);

    // Test 2: holding the key for 20 frames launches exactly once.
    do_reset();
    acks = 0;
    for (int k = 0; k < 20; k++) begin
      keycode = FIRE;
      tick(1);
      if (fire_ack === 1'b1) acks++;
    end
    keycode = 8'h00;
    tick(1);
    check("t2_launch_count", 32'(acks), 32'd1);
    check("t2_active", 32'(missile_active), 32'd1);

    // Test 3: second press inside cooldown dropped; press 9 frames later accepted.
    do_reset();
    keycode = FIRE; tick(1);
    check("t3_first_ack", 32'(fire_ack), 32'd1);
    keycode = 8'h00; tick(2);
    keycode = FIRE; tick(1);
    check("t3_cooldown_ack", 32'(fire_ack), 32'd0);
    check("t3_cooldown_active", 32'(missile_active), 32'd1);
    keycode = 8'h00; tick(5);
    keycode = FIRE; tick(1);
    check("t3_late_ack", 32'(fire_ack), 32'd1);
    check("t3_late_active", 32'(missile_active), 32'd3);
    keycode = 8'h00; tick(1);

    // Test 4: fill all slots, full pool rejects, freed slot refilled next frame.
    do_reset();
    for (int k = 0; k < N; k++) press_and_wait();
    check("t4_full", 32'(missile_active), 32'hF);
    keycode = FIRE; tick(1);
    check("t4_full_ack", 32'(fire_ack), 32'd0);
    keycode = 8'h00; tick(1);
    collision = 4'b0100;
    keycode = FIRE; tick(1);
    check("t4_freed_same_frame_ack", 32'(fire_ack), 32'd0);
    check("t4_after_hit", 32'(missile_active), 32'b1011);
    check("t4_hit_y2", 32'(slot_y(2)), 32'd0);
    collision = '0;
    keycode = 8'h00; tick(1);
    keycode = FIRE; tick(1);
    check("t4_refill_ack", 32'(fire_ack), 32'd1);
    check("t4_refill_active", 32'(missile_active), 32'hF);
    check("t4_refill_x2", 32'(slot_x(2)), 32'd316);
    check("t4_refill_y2", 32'(slot_y(2)), 32'd400);
    keycode = 8'h00; tick(1);

    // Test 5: retirement at the top edge and 10-bit X truncation.
    do_reset();
    ship_x = 10'd1020;
    ship_y = 10'd5;
    keycode = FIRE; tick(1);
    check("t5_x0_trunc", 32'(slot_x(0)), 32'd12);
    check("t5_y0", 32'(slot_y(0)), 32'd5);
    keycode = 8'h00; tick(1);
    check("t5_y0_step", 32'(slot_y(0)), 32'd1);
    check("t5_still_active", 32'(missile_active), 32'd1);
    tick(1);
    check("t5_retired", 32'(missile_active), 32'd0);
    check("t5_retired_x0", 32'(slot_x(0)), 32'd0);
    check("t5_retired_y0", 32'(slot_y(0)), 32'd0);
    ship_x = 10'd300;
    ship_y = 10'd400;

    // Test 6: reset mid-flight with the key held; no launch until re-press.
    do_reset();
    for (int k = 0; k < 3; k++) press_and_wait();
    check("t6_three", 32'(missile_active), 32'b0111);
    keycode = FIRE;
    rst = 1'b1;
    tick(1);
    check("t6_rst_active", 32'(missile_active), 32'd0);
    check("t6_rst_ack", 32'(fire_ack), 32'd0);
    rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      if (fire_ack !== 1'b0) acks++;
    end
    check("t6_held_no_launch", 32'(acks), 32'd0);
    check("t6_held_active", 32'(missile_active), 32'd0);
    keycode = 8'h00; tick(1);
    keycode = FIRE; tick(1);
    check("t6_repress_ack", 32'(fire_ack), 32'd1);
    check("t6_repress_active", 32'(missile_active), 32'd1);
    keycode = 8'h00; tick(2);

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
